// File: rtl/usb_rx_packet_ctrl.sv
// Receive-side USB packet framer: detects start, checks SYNC and PID complement,
// counts post-SYNC bytes and forwards each one to PID decode as a write strobe.
module usb_rx_packet_ctrl #(
  parameter int unsigned MAX_BYTES = 67,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       eop,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic [3:0] rx_pid,
  output logic       packet_done,
  output logic       r_error
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_SYNC, CHECK_SYNC, WAIT_PID, CHECK_PID,
    RCV, STORE, DONE, ERR, EIDLE
  } state_t;

  state_t           state, next_state;
  logic [7:0]       data_q;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             eop_q;

  logic start_c, pid_ok_c, overflow_c, end_ok_c;
  logic wr_c, pid_c, done_c, err_set_c;

  // Status terms shared by next-state and output logic
  assign pid_ok_c   = (data_q[7:4] == ~data_q[3:0]);
  assign overflow_c = (byte_cnt >= CNT_W'(MAX_BYTES));
  assign end_ok_c   = (bit_cnt == 3'd0) && (byte_cnt != '0);
  assign start_c    = (state == IDLE) && d_edge;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next state; an EOP that arrives with byte_received is honoured one cycle later via eop_q
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (d_edge) next_state = WAIT_SYNC;
      WAIT_SYNC:  if (byte_received) next_state = CHECK_SYNC;
                  else if (eop)      next_state = end_ok_c ? DONE : ERR;
      CHECK_SYNC: if (data_q != SYNC_BYTE || eop_q) next_state = eop_q ? EIDLE : ERR;
                  else                              next_state = WAIT_PID;
      WAIT_PID:   if (byte_received) next_state = CHECK_PID;
                  else if (eop)      next_state = end_ok_c ? DONE : ERR;
      CHECK_PID:  if (!pid_ok_c) next_state = eop_q ? EIDLE : ERR;
                  else           next_state = eop_q ? DONE : RCV;
      RCV:        if (byte_received) next_state = STORE;
                  else if (eop)      next_state = end_ok_c ? DONE : ERR;
      STORE:      if (overflow_c) next_state = eop_q ? EIDLE : ERR;
                  else            next_state = eop_q ? DONE : RCV;
      DONE:       next_state = IDLE;
      ERR:        if (eop || eop_q) next_state = EIDLE;
      EIDLE:      if (shift_enable) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Output decode; results are registered below
  always_comb begin
    wr_c      = 1'b0;
    pid_c     = 1'b0;
    done_c    = (next_state == DONE);
    err_set_c = (next_state == ERR) || (next_state == EIDLE);
    case (state)
      CHECK_PID: begin
        wr_c  = pid_ok_c;
        pid_c = pid_ok_c;
      end
      STORE:   wr_c = !overflow_c;
      default: ;
    endcase
  end

  // Byte latch, bit/byte counters and the one-cycle EOP memory
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      eop_q    <= 1'b0;
    end else begin
      eop_q <= eop;
      if (byte_received) data_q <= rcv_data;
      if (start_c || byte_received) bit_cnt <= '0;
      else if (shift_enable)        bit_cnt <= bit_cnt + 3'd1;
      if (start_c)   byte_cnt <= '0;
      else if (wr_c) byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rcving      <= 1'b0;
      w_enable    <= 1'b0;
      w_data      <= '0;
      rx_pid      <= '0;
      packet_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      rcving      <= (next_state != IDLE);
      w_enable    <= wr_c;
      packet_done <= done_c;
      if (wr_c)  w_data <= data_q;
      if (pid_c) rx_pid <= data_q[3:0];
      if (start_c)        r_error <= 1'b0;
      else if (err_set_c) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: bit-level stimulus with a queue of expected writes.
`timescale 1ns/1ps
module tb_usb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       eop = 1'b0;
  logic       rcving, w_enable, packet_done, r_error;
  logic [7:0] w_data;
  logic [3:0] rx_pid;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_pd_cyc = -1;
  int   pd_cnt = 0;
  int   wr_cnt = 0;
  int   pd0 = 0;
  int   wr0 = 0;
  logic prev_we = 1'b0;

  usb_rx_packet_ctrl dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .eop(eop),
    .rcving(rcving), .w_enable(w_enable), .w_data(w_data), .rx_pid(rx_pid),
    .packet_done(packet_done), .r_error(r_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pop scoreboard on every write, police packet_done timing
  always @(negedge clk) begin
    if (n_rst) begin
      if (w_enable) begin
        exp_t e;
        wr_cnt++;
        check("w_enable_not_b2b", 32'(prev_we), 32'd0);
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("w_data", 32'(w_data), 32'(e.data));
          check("w_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (packet_done) begin
        pd_cnt++;
        check("pd_cycle", 32'(cyc), 32'(exp_pd_cyc));
        exp_pd_cyc = -1;
      end
    end
    prev_we = w_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic br, input logic [7:0] d, input logic e);
    shift_enable  = 1'b1;
    byte_received = br;
    if (br) rcv_data = d;
    eop = e;
    tick();
    shift_enable  = 1'b0;
    byte_received = 1'b0;
    eop = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic wr, input logic with_eop);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8'h00, 1'b0);
    if (wr) sb.push_back('{b, cyc + 2});
    if (with_eop) exp_pd_cyc = cyc + 2;
    send_bit(1'b1, b, with_eop);
  endtask

  task automatic send_eop(input logic clean);
    if (clean) exp_pd_cyc = cyc + 1;
    send_bit(1'b0, 8'h00, 1'b1);
  endtask

  task automatic start_pkt();
    pd0 = pd_cnt;
    wr0 = wr_cnt;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    check("start_rcving", 32'(rcving), 32'd1);
    check("start_r_error_clear", 32'(r_error), 32'd0);
    tick();
  endtask

  task automatic end_pkt(input string tag, input int exp_pd, input logic exp_err, input int exp_wr);
    send_bit(1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    check({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_packet_done_count"}, 32'(pd_cnt - pd0), 32'(exp_pd));
    check({tag, "_write_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, "_r_error"}, 32'(r_error), 32'(exp_err));
    check({tag, "_rcving_low"}, 32'(rcving), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rcving"}, 32'(rcving), 32'd0);
    check({tag, "_w_enable"}, 32'(w_enable), 32'd0);
    check({tag, "_w_data"}, 32'(w_data), 32'd0);
    check({tag, "_rx_pid"}, 32'(rx_pid), 32'd0);
    check({tag, "_packet_done"}, 32'(packet_done), 32'd0);
    check({tag, "_r_error"}, 32'(r_error), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    repeat (2) tick();

    // Good ACK
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hD2, 1'b1, 1'b0);
    send_eop(1'b1);
    end_pkt("ack", 1, 1'b0, 1);
    check("ack_rx_pid", 32'(rx_pid), 32'h2);

    // DATA0 with 4 payload bytes and a stray d_edge mid-packet
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'hAB, 1'b1, 1'b0);
    send_byte(8'hCD, 1'b1, 1'b0);
    send_eop(1'b1);
    end_pkt("data0", 1, 1'b0, 5);
    check("data0_rx_pid", 32'(rx_pid), 32'h3);

    // Bad PID complement
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC4, 1'b0, 1'b0);
    check("badpid_r_error", 32'(r_error), 32'd1);
    send_byte(8'h55, 1'b0, 1'b0);
    send_eop(1'b0);
    check("badpid_rcving_in_eidle", 32'(rcving), 32'd1);
    end_pkt("badpid", 0, 1'b1, 0);
    check("badpid_rx_pid_kept", 32'(rx_pid), 32'h3);

    // Bad SYNC
    start_pkt();
    send_byte(8'h81, 1'b0, 1'b0);
    check("badsync_r_error", 32'(r_error), 32'd1);
    send_byte(8'hD2, 1'b0, 1'b0);
    send_eop(1'b0);
    end_pkt("badsync", 0, 1'b1, 0);

    // EOP after 3 bits of a partial byte
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hD2, 1'b1, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 8'h00, 1'b0);
    send_eop(1'b0);
    end_pkt("partial", 0, 1'b1, 2);

    // 68 post-SYNC bytes: 67 writes then overflow error
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 66; i++) send_byte(8'(i + 1), 1'b1, 1'b0);
    check("overflow_no_error_at_max", 32'(r_error), 32'd0);
    send_byte(8'hEE, 1'b0, 1'b0);
    check("overflow_r_error", 32'(r_error), 32'd1);
    send_eop(1'b0);
    end_pkt("overflow", 0, 1'b1, 67);

    // EOP coinciding with byte_received
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b1);
    end_pkt("coincide", 1, 1'b0, 2);

    // Asynchronous reset with a write in flight
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 8'h00, 1'b0);
    shift_enable = 1'b1;
    byte_received = 1'b1;
    rcv_data = 8'h77;
    tick();
    shift_enable = 1'b0;
    byte_received = 1'b0;
    n_rst = 1'b0;
    #1;
    sb.delete();
    exp_pd_cyc = -1;
    check_all_zero("midreset");
    pd0 = pd_cnt;
    wr0 = wr_cnt;
    repeat (3) tick();
    check_all_zero("midreset_held");
    n_rst = 1'b1;
    repeat (10) tick();
    check("midreset_no_stray_write", 32'(wr_cnt - wr0), 32'd0);
    check("midreset_no_stray_done", 32'(pd_cnt - pd0), 32'd0);

    // Recovery after reset
    start_pkt();
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hD2, 1'b1, 1'b0);
    send_eop(1'b1);
    end_pkt("recover", 1, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
